inv_round: RTL
==============

INV_ROUND -- requirements
Module: inv_round

Interface
REQ-001 SHALL have parameter DATA_W, default 128, state width in bits; only 128 is supported.
REQ-002 SHALL have parameter MIX_EN, default 1, meaning InvMixColumns is applied (1) or bypassed for the inverse of the final cipher round (0).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_valid_in  input  1  input block valid.
REQ-006 SHALL have port key_valid_in  input  1  round key valid.
REQ-007 SHALL have port data_in  input  DATA_W  ciphertext-side state.
REQ-008 SHALL have port round_key  input  DATA_W  round key for this round.
REQ-009 SHALL have port valid_out  output  1  output block valid.
REQ-010 SHALL have port data_out  output  DATA_W  recovered state.

Function
REQ-011 SHALL map state bytes FIPS-197 column-major: byte k = data[127-8k -: 8], row r = k mod 4, column c = k div 4.
REQ-012 SHALL compute the exact inverse of one encryption round: AddRoundKey -> InvMixColumns -> InvShiftRows -> InvSubBytes, in that order.
REQ-013 SHALL implement four registered pipeline stages, one per step; stage 2 SHALL pass data unchanged when MIX_EN = 0.
REQ-014 SHALL accept a block only when data_valid_in = 1 and key_valid_in = 1 in the same cycle; either alone SHALL be ignored.
REQ-015 SHALL sample data_in and round_key together on acceptance; round_key is not required stable afterwards.
REQ-016 SHALL assert valid_out exactly 4 cycles after acceptance, with the corresponding data_out, for one cycle per block.
REQ-017 SHALL sustain one accepted block per cycle with no stall and no backpressure.
REQ-018 SHALL preserve bubbles: the valid pattern at the output equals the accepted-valid pattern at the input, delayed 4 cycles.
REQ-019 SHALL load each stage's data register only when that stage's input valid is 1, and hold it otherwise.
REQ-020 SHALL therefore hold data_out at the last valid result while valid_out = 0.
REQ-021 SHALL implement InvShiftRows as a cyclic right rotation of row r by r bytes.
REQ-022 SHALL implement InvSubBytes using the FIPS-197 inverse S-box on all 16 bytes.
REQ-023 SHALL implement InvMixColumns as multiplication of each column by {0e,0b,0d,09}, circulant, in GF(2^8) mod x^8+x^4+x^3+x+1.
REQ-024 SHALL have no internal state beyond the four stage valid bits and the four stage data registers.

Reset
REQ-025 SHALL, while reset = 1 at a clock edge, clear all stage valid bits and all stage data registers to 0.
REQ-026 SHALL drive valid_out = 0 and data_out = 0 on the cycle after reset is sampled high.
REQ-027 SHALL discard all in-flight blocks on reset mid-operation; none appear at the output after reset is released.
REQ-028 SHALL ignore inputs in any cycle where reset = 1.
REQ-029 SHALL accept a new block on the first edge after reset deasserts.

Verification
REQ-030 MIX_EN=1: data_in = a49c7ff2689f352b6b5bea43026a5049, round_key = a0fafe1788542cb123a339392a6c7605, both valids = 1 for one cycle -> valid_out = 1 four cycles later with data_out = 193de3bea0f4e22b9ac68d2ae9f84808, then 0.
REQ-031 MIX_EN=0: data_in = 3925841d02dc09fbdc118597196a0b32, round_key = d014f9a8c9ee2589e13f0cc8b6630ca6 -> data_out = eb40f21e592e38848ba113e71bc342d2 after 4 cycles.
REQ-032 Back-to-back pipelining: 8 consecutive accepted random blocks, then a valid gap of 1 cycle, then 3 more -> 8 consecutive results, a 1-cycle gap, then 3 results.
REQ-033 Results in the back-to-back test SHALL each equal the reference model (encrypt-round of the output == input), and data_out SHALL hold during gaps.
REQ-034 Handshake qualification: data_valid_in = 1 with key_valid_in = 0, then key_valid_in = 1 with data_valid_in = 0 -> valid_out never asserts and data_out is unchanged.
REQ-035 Mid-pipeline reset: accept 3 blocks, assert reset for 1 cycle 2 cycles after the first -> valid_out = 0 and data_out = 0 thereafter.
REQ-036 In the mid-pipeline reset test, a block accepted right after release SHALL emerge 4 cycles later, correct.
REQ-037 Round-trip: random state S and key K driven through the encryption round and then inv_round with the same K (both MIX_EN settings) -> data_out = S for 1000 iterations.

Source files
------------

// File: rtl/inv_round.sv
// Inverse of one AES cipher round as a four-stage pipeline:
// AddRoundKey -> InvMixColumns -> InvShiftRows -> InvSubBytes, one registered stage each.
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high; clears every stage valid and data register
//   data_valid_in  input block valid
//   key_valid_in   round key valid; a block is accepted only with both valids high
//   data_in        ciphertext-side state (FIPS-197 column-major byte order)
//   round_key      round key, sampled together with data_in
//   valid_out      result valid, exactly four cycles after acceptance
//   data_out       recovered state; holds the last result while valid_out is low
// MIX_EN = 0 bypasses InvMixColumns, which inverts the final cipher round.
module inv_round #(
    parameter int unsigned DATA_W = 128,
    parameter bit          MIX_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_valid_in,
    input  logic              key_valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] round_key,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out
);

    localparam int unsigned NUM_BYTES = 16;
    localparam int unsigned NUM_COLS  = 4;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Byte k of the state sits at the MSB end: k = 0 is bits [127:120].
    function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] s, input int k);
        return s[DATA_W-1-8*k -: 8];
    endfunction

    // Multiply by x in GF(2^8) mod x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Each column times the circulant {0e,0b,0d,09}; 9/b/d/e built from x, x^2, x^3 multiples.
    function automatic logic [DATA_W-1:0] inv_mix_columns(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        r = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int i = 0; i < 4; i++) begin
                a[i]  = get_byte(s, 4*c + i);
                x2    = xtime(a[i]);
                x4    = xtime(x2);
                x8    = xtime(x4);
                m9[i] = x8 ^ a[i];
                mb[i] = x8 ^ x2 ^ a[i];
                md[i] = x8 ^ x4 ^ a[i];
                me[i] = x8 ^ x4 ^ x2;
            end
            r[DATA_W-1-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            r[DATA_W-1-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            r[DATA_W-1-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            r[DATA_W-1-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end
        return r;
    endfunction

    // Row r rotates right by r: output column c takes input column (c - r) mod 4.
    function automatic logic [DATA_W-1:0] inv_shift_rows(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[DATA_W-1-8*(4*c+row) -: 8] = get_byte(s, 4*((c + 4 - row) % 4) + row);
            end
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] inv_sub_bytes(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_BYTES; k++) begin
            r[DATA_W-1-8*k -: 8] = INV_SBOX[get_byte(s, k)];
        end
        return r;
    endfunction

    logic              accept_c;
    logic [3:0]        stage_valid;
    logic [DATA_W-1:0] stage1_data;
    logic [DATA_W-1:0] stage2_data;
    logic [DATA_W-1:0] stage3_data;
    logic [DATA_W-1:0] stage4_data;
    logic [DATA_W-1:0] mix_c;

    assign accept_c = data_valid_in & key_valid_in;

    // Stage-2 function; a straight pass-through when the final round is being inverted.
    always_comb begin
        mix_c = stage1_data;
        if (MIX_EN) begin
            mix_c = inv_mix_columns(stage1_data);
        end
    end

    // Pipeline: valids shift every cycle, each data register loads only behind a valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage_valid <= '0;
            stage1_data <= '0;
            stage2_data <= '0;
            stage3_data <= '0;
            stage4_data <= '0;
        end else begin
            stage_valid <= {stage_valid[2:0], accept_c};
            if (accept_c) begin
                stage1_data <= data_in ^ round_key;
            end
            if (stage_valid[0]) begin
                stage2_data <= mix_c;
            end
            if (stage_valid[1]) begin
                stage3_data <= inv_shift_rows(stage2_data);
            end
            if (stage_valid[2]) begin
                stage4_data <= inv_sub_bytes(stage3_data);
            end
        end
    end

    assign valid_out = stage_valid[3];
    assign data_out  = stage4_data;

endmodule
